// File: rtl/pulse_spacer_f.sv
// pulse_spacer_f: absorbs bursts of single-cycle events into a saturating pending counter and
// re-emits them as single-cycle pulses spaced GAP clocks apart for a fast-to-slow synchronizer.
module pulse_spacer_f #(
    parameter int CNT_W = 4,
    parameter int GAP   = 32
) (
    input  logic             clk_f,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             clr_ovf,
    output logic             pulse_f,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] PEND_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] PEND_ONE   = CNT_W'(1);
    localparam logic [15:0]      GAP_RELOAD = 16'(GAP - 1);

    typedef enum logic {
        READY   = 1'b0,
        SPACING = 1'b1
    } phase_t;

    phase_t           phase;
    logic [15:0]      gap_cnt;
    logic [15:0]      gap_nxt;
    logic [CNT_W-1:0] pend_nxt;
    logic             ovf_nxt;
    logic             emit;
    logic             drop;

    // The spacing phase lives entirely in gap_cnt; the enum only names it.
    assign phase = (gap_cnt == 16'd0) ? READY : SPACING;
    assign busy  = (pend_cnt != '0) || (phase == SPACING);

    always_comb begin
        emit     = 1'b0;
        drop     = 1'b0;
        pend_nxt = pend_cnt;
        gap_nxt  = gap_cnt;
        ovf_nxt  = ovf;

        emit = (phase == READY) && (pend_cnt != '0);

        if (emit) begin
            gap_nxt = GAP_RELOAD;
        end else if (phase == SPACING) begin
            gap_nxt = gap_cnt - 16'd1;
        end

        // An event coinciding with an emit is a net-zero change, so it can never be dropped.
        if (emit && !evt_in) begin
            pend_nxt = pend_cnt - PEND_ONE;
        end else if (evt_in && !emit) begin
            if (pend_cnt == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_nxt = pend_cnt + PEND_ONE;
            end
        end

        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            pulse_f  <= 1'b0;
            pend_cnt <= '0;
            ovf      <= 1'b0;
            gap_cnt  <= 16'd0;
        end else begin
            pulse_f  <= emit;
            pend_cnt <= pend_nxt;
            ovf      <= ovf_nxt;
            gap_cnt  <= gap_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_spacer_f.sv
// tb_pulse_spacer_f: table vectors, directed corner sequences and random traffic against an
// event/timestamp reference model of pulse_spacer_f.
module tb_pulse_spacer_f;

    localparam int CNT_W = 4;
    localparam int GAP   = 32;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic             clk_f = 1'b0;
    logic             rst_n = 1'b0;
    logic             evt_in = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             pulse_f;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;
    logic             busy;

    pulse_spacer_f #(.CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk_f    (clk_f),
        .rst_n    (rst_n),
        .evt_in   (evt_in),
        .clr_ovf  (clr_ovf),
        .pulse_f  (pulse_f),
        .pend_cnt (pend_cnt),
        .ovf      (ovf),
        .busy     (busy)
    );

    always #5 clk_f = ~clk_f;

    typedef struct {
        logic       evt;
        logic       clr;
        logic       exp_pulse;
        logic [3:0] exp_pend;
        logic       exp_ovf;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_count = 0;

    // Reference model: a pending-event count plus the edge index of the last emitted pulse.
    int cyc;
    int m_pend;
    int m_last;
    bit m_ovf;
    bit m_pulse;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        cyc     = 0;
        m_pend  = 0;
        m_last  = -1000000;
        m_ovf   = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic modelEdge(input bit e, input bit c);
        bit emit;
        bit dropped;
        cyc++;
        emit    = (m_pend > 0) && (cyc >= m_last + GAP);
        dropped = e && !emit && (m_pend == MAXP);
        if (emit) m_last = cyc;
        if (emit && !e) m_pend--;
        else if (e && !emit && !dropped) m_pend++;
        if (dropped) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_pulse = emit;
    endtask

    task automatic compareModel();
        bit m_busy;
        m_busy = (m_pend != 0) || (cyc < m_last + GAP - 1);
        checkOutput("pulse_f", int'(pulse_f), int'(m_pulse));
        checkOutput("pend_cnt", int'(pend_cnt), m_pend);
        checkOutput("ovf", int'(ovf), int'(m_ovf));
        checkOutput("busy", int'(busy), int'(m_busy));
    endtask

    task automatic applyStimulus(input logic e, input logic c);
        evt_in  = e;
        clr_ovf = c;
        @(posedge clk_f);
        modelEdge(e, c);
        #1;
        if (pulse_f) pulse_count++;
        compareModel();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pulse_f"}, int'(pulse_f), 0);
        checkOutput({tag, "_pend_cnt"}, int'(pend_cnt), 0);
        checkOutput({tag, "_ovf"}, int'(ovf), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic doReset();
        rst_n   = 1'b0;
        evt_in  = 1'b0;
        clr_ovf = 1'b0;
        #1;
        checkResetState("reset");
        repeat (2) @(posedge clk_f);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 1000 && busy; i++) applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_drain_busy"}, int'(busy), 0);
    endtask

    initial begin
        modelReset();
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1};

        doReset();

        // Single event: pend rises after the sampling edge, pulse follows one edge later.
        repeat (9) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("single_pend_after_evt", int'(pend_cnt), 1);
        checkOutput("single_no_pulse_yet", int'(pulse_f), 0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("single_pulse", int'(pulse_f), 1);
        checkOutput("single_pend_zero", int'(pend_cnt), 0);
        repeat (GAP - 2) applyStimulus(1'b0, 1'b0);
        checkOutput("single_busy_before_end", int'(busy), 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("single_busy_low", int'(busy), 0);

        // Table vectors from idle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].evt, vecs[i].clr);
            checkOutput($sformatf("vec%0d_pulse", i), int'(pulse_f), int'(vecs[i].exp_pulse));
            checkOutput($sformatf("vec%0d_pend", i), int'(pend_cnt), int'(vecs[i].exp_pend));
            checkOutput($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].exp_ovf));
            checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
        end
        drain("vec");

        // Burst of five: peak of four pending, five pulses.
        doReset();
        pulse_count = 0;
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("burst_peak", int'(pend_cnt), 4);
        drain("burst");
        checkOutput("burst_pulses", pulse_count, 5);
        checkOutput("burst_pend_end", int'(pend_cnt), 0);

        // Overflow: 40 held events, 17 accepted, then clear/drop collision.
        doReset();
        pulse_count = 0;
        repeat (40) applyStimulus(1'b1, 1'b0);
        checkOutput("ovf_pend_sat", int'(pend_cnt), MAXP);
        checkOutput("ovf_set", int'(ovf), 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("ovf_clr_vs_drop", int'(ovf), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ovf_cleared", int'(ovf), 0);
        drain("ovf");
        checkOutput("ovf_pulses", pulse_count, 17);

        // Reset mid-burst while pend_cnt = 7 and a pulse is in flight.
        doReset();
        repeat (8) applyStimulus(1'b1, 1'b0);
        repeat (25) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("mid_pulse_high", int'(pulse_f), 1);
        checkOutput("mid_pend7", int'(pend_cnt), 7);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("mid_reset");
        @(posedge clk_f);
        #1;
        rst_n = 1'b1;
        modelReset();
        pulse_count = 0;
        repeat (80) applyStimulus(1'b0, 1'b0);
        checkOutput("mid_no_pulses", pulse_count, 0);

        // Random traffic at varying densities.
        doReset();
        for (int ph = 0; ph < 6; ph++) begin
            int dens;
            dens = int'($urandom_range(5, 100));
            for (int i = 0; i < 400; i++) begin
                applyStimulus(logic'(int'($urandom_range(0, 99)) < dens),
                              logic'($urandom_range(0, 39) == 0));
            end
        end
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
